// File: rtl/uart_tx_if.sv
// uart_tx handshake bundle: baud strobe, request/data in, serial line and status out.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 b_tick;
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output b_tick, tx_start, tx_data,
    input  tx, tx_busy, tx_done
  );

  modport slave (
    input  b_tick, tx_start, tx_data,
    output tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, one stop bit.
// Bit timing comes from an external OVERSAMPLE-x baud strobe; all outputs are registered.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      reset,
  uart_tx_if.slave  bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  // Next-state, bit timing and registered-output values.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bit_end = 1'b0;

    if (state_q != IDLE && bus.b_tick) begin
      if (tick_q == TW'(OVERSAMPLE - 1)) begin
        tick_d  = '0;
        bit_end = 1'b1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.tx_start) begin
          // Parity is fixed at acceptance from the latched byte, since the shift register is consumed later.
          shift_d = bus.tx_data;
          par_d   = (^bus.tx_data) ^ (PARITY_ODD != 0);
          tick_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_d = bit_q + BW'(1);
            tx_d  = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and forces the line idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule
